// File: rtl/citron_pkg.sv
// Shared Citron bus widths, arbiter state encoding and helpers.
// Imported by the arbiter and its round-robin picker.
package citron_pkg;

  localparam int CITRON_ADDR_W = 8;
  localparam int CITRON_DATA_W = 32;
  localparam int CITRON_IDX_W  = 3;

  localparam logic [CITRON_DATA_W-1:0] CITRON_TIMEOUT_DATA =
    32'hDEAD_BEEF;

  typedef enum logic {
    ARB_IDLE,
    ARB_BUSY
  } arb_state_t;

  function automatic logic [CITRON_IDX_W-1:0] rr_next(
    input logic [CITRON_IDX_W-1:0] g,
    input int                      n
  );
    if (int'(g) == n - 1) return '0;
    return g + 3'd1;
  endfunction

endpackage

// File: rtl/citron_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr.
// Ports: req (request vector), ptr (start index), idx (winner), valid.
module citron_rr_pick
  import citron_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]            req,
  input  logic [CITRON_IDX_W-1:0] ptr,
  output logic [CITRON_IDX_W-1:0] idx,
  output logic                    valid
);

  always_comb begin
    int j;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = CITRON_IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/citron_arbiter.sv
// Round-robin arbiter sharing the Citron bus between NUM_MASTERS masters.
// Ports: clk_i, rst_i (sync, active high); per-master m_addr/m_rdy/m_wr/
// m_writedata in, m_readdata/m_stall out; citron_* bus to the slave
// fabric; grant_o, busy_o, sticky err_unmapped_o status.
// Optional stall watchdog with `define CITRON_ARB_TIMEOUT_EN, which adds
// the sticky err_timeout_o port.
module citron_arbiter
  import citron_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NUM_MASTERS*8-1:0]         m_addr,
  input  logic [NUM_MASTERS-1:0]           m_rdy,
  input  logic [NUM_MASTERS-1:0]           m_wr,
  input  logic [NUM_MASTERS*32-1:0]        m_writedata,
  output logic [CITRON_DATA_W-1:0]         m_readdata,
  output logic [NUM_MASTERS-1:0]           m_stall,
  output logic [CITRON_ADDR_W-1:0]         citron_addr,
  output logic                             citron_rdy,
  output logic                             citron_wr,
  output logic [CITRON_DATA_W-1:0]         citron_writedata,
  input  logic [CITRON_DATA_W-1:0]         citron_readdata,
  input  logic                             citron_stall,
  input  logic                             citron_match,
  output logic [CITRON_IDX_W-1:0]          grant_o,
  output logic                             busy_o,
  output logic                             err_unmapped_o
`ifdef CITRON_ARB_TIMEOUT_EN
  ,
  output logic                             err_timeout_o
`endif
);

  arb_state_t state_q, state_d;

  logic [CITRON_IDX_W-1:0] grant_q, grant_d;
  logic [CITRON_IDX_W-1:0] rr_q, rr_d;
  logic                    err_q, err_d;

  logic [CITRON_IDX_W-1:0] pick_idx;
  logic                    pick_vld;

  logic [NUM_MASTERS-1:0]   gnt_oh;
  logic [CITRON_ADDR_W-1:0] sel_addr;
  logic                     sel_rdy;
  logic                     sel_wr;
  logic [CITRON_DATA_W-1:0] sel_wd;

  citron_rr_pick #(
    .N(NUM_MASTERS)
  ) u_pick (
    .req  (m_rdy),
    .ptr  (rr_q),
    .idx  (pick_idx),
    .valid(pick_vld)
  );

  // One-hot grant keeps the mux free of out-of-range indexing.
  always_comb begin
    gnt_oh   = '0;
    sel_addr = '0;
    sel_rdy  = 1'b0;
    sel_wr   = 1'b0;
    sel_wd   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      gnt_oh[i] = (grant_q == CITRON_IDX_W'(i));
      if (gnt_oh[i]) begin
        sel_addr = m_addr[i*8 +: 8];
        sel_rdy  = m_rdy[i];
        sel_wr   = m_wr[i];
        sel_wd   = m_writedata[i*32 +: 32];
      end
    end
  end

`ifdef CITRON_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] to_cnt_q;
  logic            to_err_q, to_err_d;
  logic            to_hit;

  assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Cleared while idle, so it starts at zero on each BUSY entry.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= to_err_d;
      if (state_q == ARB_IDLE) begin
        to_cnt_q <= '0;
      end else if (citron_stall) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  assign err_timeout_o = to_err_q;
`endif

  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    rr_d             = rr_q;
    err_d            = err_q;
    citron_addr      = '0;
    citron_rdy       = 1'b0;
    citron_wr        = 1'b0;
    citron_writedata = '0;
    m_stall          = m_rdy;
    m_readdata       = '0;
`ifdef CITRON_ARB_TIMEOUT_EN
    to_err_d         = to_err_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        citron_addr      = sel_addr;
        citron_rdy       = sel_rdy;
        citron_wr        = sel_wr;
        citron_writedata = sel_wd;
        if (!sel_rdy) begin
          // Granted master gave up: drop it, keep the pointer.
          state_d = ARB_IDLE;
        end else if (!citron_stall) begin
          m_stall    = m_rdy & ~gnt_oh;
          m_readdata = citron_match ? citron_readdata : '0;
          if (!citron_match) err_d = 1'b1;
          rr_d    = rr_next(grant_q, NUM_MASTERS);
          state_d = ARB_IDLE;
        end
`ifdef CITRON_ARB_TIMEOUT_EN
        else if (to_hit) begin
          m_stall    = m_rdy & ~gnt_oh;
          m_readdata = CITRON_TIMEOUT_DATA;
          to_err_d   = 1'b1;
          rr_d       = rr_next(grant_q, NUM_MASTERS);
          state_d    = ARB_IDLE;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end

  assign grant_o        = grant_q;
  assign busy_o         = (state_q == ARB_BUSY);
  assign err_unmapped_o = err_q;

endmodule

// File: tb/tb_citron_arbiter.sv
// Directed self-checking bench for citron_arbiter (two masters).
// Define CITRON_ARB_TIMEOUT_EN to also exercise the stall watchdog.
module tb_citron_arbiter;

  logic        clk;
  logic        rst_i;
  logic [15:0] m_addr;
  logic [1:0]  m_rdy;
  logic [1:0]  m_wr;
  logic [63:0] m_writedata;
  logic [31:0] m_readdata;
  logic [1:0]  m_stall;
  logic [7:0]  citron_addr;
  logic        citron_rdy;
  logic        citron_wr;
  logic [31:0] citron_writedata;
  logic [31:0] citron_readdata;
  logic        citron_stall;
  logic        citron_match;
  logic [2:0]  grant_o;
  logic        busy_o;
  logic        err_unmapped_o;
`ifdef CITRON_ARB_TIMEOUT_EN
  logic        err_timeout_o;
`endif

  int passed = 0;
  int total  = 0;

  citron_arbiter #(
    .NUM_MASTERS   (2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .m_addr          (m_addr),
    .m_rdy           (m_rdy),
    .m_wr            (m_wr),
    .m_writedata     (m_writedata),
    .m_readdata      (m_readdata),
    .m_stall         (m_stall),
    .citron_addr     (citron_addr),
    .citron_rdy      (citron_rdy),
    .citron_wr       (citron_wr),
    .citron_writedata(citron_writedata),
    .citron_readdata (citron_readdata),
    .citron_stall    (citron_stall),
    .citron_match    (citron_match),
    .grant_o         (grant_o),
    .busy_o          (busy_o),
    .err_unmapped_o  (err_unmapped_o)
`ifdef CITRON_ARB_TIMEOUT_EN
    ,
    .err_timeout_o   (err_timeout_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst_i           = 1'b1;
    m_addr          = '0;
    m_rdy           = 2'b11;
    m_wr            = '0;
    m_writedata     = '0;
    citron_readdata = '0;
    citron_stall    = 1'b0;
    citron_match    = 1'b1;

    // Reset state: requesters stalled, bus idle.
    nxt();
    smp();
    chk("rst_stall", 32'(m_stall), 32'h3);
    chk("rst_crdy", 32'(citron_rdy), 32'h0);
    chk("rst_busy", 32'(busy_o), 32'h0);
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_err", 32'(err_unmapped_o), 32'h0);
    chk("rst_caddr", 32'(citron_addr), 32'h0);
    nxt();
    m_rdy = 2'b00;
    rst_i = 1'b0;

    // Master 0 write to 0xFE.
    m_addr[7:0]       = 8'hFE;
    m_writedata[31:0] = 32'h1234_5678;
    m_wr              = 2'b01;
    m_rdy             = 2'b01;
    smp();
    chk("w0_idle_crdy", 32'(citron_rdy), 32'h0);
    chk("w0_idle_stall", 32'(m_stall), 32'h1);
    nxt();
    smp();
    chk("w0_crdy", 32'(citron_rdy), 32'h1);
    chk("w0_cwr", 32'(citron_wr), 32'h1);
    chk("w0_caddr", 32'(citron_addr), 32'hFE);
    chk("w0_cwd", citron_writedata, 32'h1234_5678);
    chk("w0_stall", 32'(m_stall), 32'h0);
    chk("w0_busy", 32'(busy_o), 32'h1);
    nxt();
    m_rdy = 2'b00;

    // rr_ptr is 1: master 1 wins, then pointer wraps to 0.
    m_addr      = {8'h20, 8'h10};
    m_writedata = {32'hBBBB_0002, 32'hAAAA_0001};
    m_wr        = 2'b11;
    m_rdy       = 2'b11;
    smp();
    chk("rr_idle_stall", 32'(m_stall), 32'h3);
    nxt();
    smp();
    chk("rr_g1", 32'(grant_o), 32'h1);
    chk("rr_g1_addr", 32'(citron_addr), 32'h20);
    chk("rr_g1_wd", citron_writedata, 32'hBBBB_0002);
    chk("rr_g1_stall", 32'(m_stall), 32'h1);
    nxt();
    m_rdy = 2'b01;
    smp();
    chk("rr_gap_busy", 32'(busy_o), 32'h0);
    nxt();
    smp();
    chk("rr_wrap_g0", 32'(grant_o), 32'h0);
    chk("rr_wrap_addr", 32'(citron_addr), 32'h10);
    chk("rr_wrap_stall", 32'(m_stall), 32'h0);
    nxt();
    m_rdy = 2'b00;

    // Fresh reset, both request together.
    rst_i = 1'b1;
    nxt();
    rst_i = 1'b0;
    m_rdy = 2'b11;
    smp();
    chk("both_idle_stall", 32'(m_stall), 32'h3);
    nxt();
    smp();
    chk("both_g0", 32'(grant_o), 32'h0);
    chk("both_g0_stall", 32'(m_stall), 32'h2);
    nxt();
    m_rdy = 2'b10;
    smp();
    chk("both_gap_stall", 32'(m_stall), 32'h2);
    nxt();
    smp();
    chk("both_g1", 32'(grant_o), 32'h1);
    chk("both_g1_stall", 32'(m_stall), 32'h0);
    nxt();
    m_rdy = 2'b00;

    // Master 1 read, slave stalls three cycles.
    m_addr[15:8] = 8'h30;
    m_wr         = 2'b00;
    citron_stall = 1'b1;
    m_rdy        = 2'b10;
    nxt();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("rd_stall_hold", 32'(m_stall), 32'h2);
      chk("rd_stall_busy", 32'(busy_o), 32'h1);
      chk("rd_stall_crdy", 32'(citron_rdy), 32'h1);
      nxt();
    end
    citron_stall    = 1'b0;
    citron_readdata = 32'hCAFE_0001;
    smp();
    chk("rd_done_stall", 32'(m_stall), 32'h0);
    chk("rd_done_data", m_readdata, 32'hCAFE_0001);
    chk("rd_done_grant", 32'(grant_o), 32'h1);
    nxt();
    m_rdy = 2'b00;

    // Unmapped read by master 0.
    m_addr[7:0]     = 8'h40;
    citron_match    = 1'b0;
    citron_readdata = 32'hFFFF_FFFF;
    m_rdy           = 2'b01;
    nxt();
    smp();
    chk("um_stall", 32'(m_stall), 32'h0);
    chk("um_data", m_readdata, 32'h0);
    chk("um_err_pre", 32'(err_unmapped_o), 32'h0);
    nxt();
    m_rdy        = 2'b00;
    citron_match = 1'b1;
    smp();
    chk("um_err_set", 32'(err_unmapped_o), 32'h1);

    // Master 1 abandons mid-stall; pointer stays at 1.
    m_rdy        = 2'b10;
    citron_stall = 1'b1;
    nxt();
    smp();
    chk("ab_busy", 32'(busy_o), 32'h1);
    chk("ab_grant", 32'(grant_o), 32'h1);
    nxt();
    m_rdy = 2'b00;
    smp();
    chk("ab_crdy", 32'(citron_rdy), 32'h0);
    nxt();
    m_rdy        = 2'b11;
    citron_stall = 1'b0;
    smp();
    chk("ab_idle", 32'(busy_o), 32'h0);
    nxt();
    smp();
    chk("ab_ptr_keep", 32'(grant_o), 32'h1);
    chk("ab_ptr_stall", 32'(m_stall), 32'h1);
    nxt();
    m_rdy = 2'b01;
    nxt();
    smp();
    chk("ab_g0", 32'(grant_o), 32'h0);
    chk("um_err_sticky", 32'(err_unmapped_o), 32'h1);
    nxt();
    m_rdy = 2'b00;

    // Reset while master 1 is stalled in BUSY.
    m_rdy        = 2'b10;
    citron_stall = 1'b1;
    nxt();
    smp();
    chk("rb_busy", 32'(busy_o), 32'h1);
    chk("rb_grant", 32'(grant_o), 32'h1);
    nxt();
    rst_i = 1'b1;
    smp();
    chk("rb_hold_stall", 32'(m_stall), 32'h2);
    nxt();
    rst_i = 1'b0;
    smp();
    chk("rb_crdy", 32'(citron_rdy), 32'h0);
    chk("rb_busy0", 32'(busy_o), 32'h0);
    chk("rb_grant0", 32'(grant_o), 32'h0);
    chk("rb_no_cmpl", 32'(m_stall), 32'h2);
    chk("rb_err_clr", 32'(err_unmapped_o), 32'h0);
    nxt();
    m_rdy        = 2'b00;
    citron_stall = 1'b0;
    nxt();
    nxt();

`ifdef CITRON_ARB_TIMEOUT_EN
    // Slave never releases stall; watchdog forces completion.
    m_rdy        = 2'b11;
    citron_stall = 1'b1;
    nxt();
    for (int i = 0; i < 7; i++) begin
      smp();
      chk("to_hold", 32'(m_stall), 32'h3);
      nxt();
    end
    smp();
    chk("to_force_stall", 32'(m_stall), 32'h2);
    chk("to_force_data", m_readdata, 32'hDEAD_BEEF);
    nxt();
    m_rdy        = 2'b10;
    citron_stall = 1'b0;
    smp();
    chk("to_err", 32'(err_timeout_o), 32'h1);
    nxt();
    smp();
    chk("to_next_grant", 32'(grant_o), 32'h1);
    chk("to_next_stall", 32'(m_stall), 32'h0);
    nxt();
    m_rdy = 2'b00;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
